// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search controller.
//   state_t   : controller state encoding
//   OWN_*     : encodings driven on mem_owner for the shared S-memory port
//   CHAR_*    : bounds of the accepted plaintext alphabet (a..z and space)
package rc4_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_INIT_GO,
    S_INIT_WAIT,
    S_KSA_GO,
    S_KSA_WAIT,
    S_DEC_GO,
    S_DEC_WAIT,
    S_CHK_SETUP,
    S_CHK_READ,
    S_CHK_SAMPLE,
    S_NEXT_KEY,
    S_FINISH
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INIT = 2'd1;
  localparam logic [1:0] OWN_KSA  = 2'd2;
  localparam logic [1:0] OWN_DEC  = 2'd3;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext-byte classifier.
//   char_in : decrypted byte
//   valid   : 1 when char_in is a lowercase letter or a space
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       valid
);

  assign valid = ((char_in >= CHAR_LO) && (char_in <= CHAR_HI)) ||
                 (char_in == CHAR_SPACE);

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key-search sequencer. For each key in [key_lo, key_hi] it
// runs the external S-init, key-schedule and decrypt engines in turn, then
// scans the decrypted message for printable text.
//   clk, reset_n                      : clock, synchronous active-low reset
//   start, key_lo, key_hi             : search request and inclusive key range
//   init/ksa/dec_start, *_done        : engine handshake pulses
//   mem_owner                         : shared S-memory grant (see OWN_*)
//   key                               : candidate key applied to the engines
//   res_addr, res_q                   : decrypted-output memory read port
//   busy, done, found                 : status
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | waiting for start; key/found hold last result
// LOAD        | reject an empty range, otherwise begin at key_lo
// INIT_GO     | pulse init_start
// INIT_WAIT   | wait for init_done
// KSA_GO      | pulse ksa_start
// KSA_WAIT    | wait for ksa_done
// DEC_GO      | pulse dec_start
// DEC_WAIT    | wait for dec_done
// CHK_SETUP   | present res_addr = byte index
// CHK_READ    | memory read in flight
// CHK_SAMPLE  | classify res_q, advance or reject key
// NEXT_KEY    | stop at key_hi, else increment key
// FINISH      | one-cycle done pulse
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int KEY_W   = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_lo,
  input  logic [KEY_W-1:0] key_hi,
  output logic             init_start,
  output logic             ksa_start,
  output logic             dec_start,
  input  logic             init_done,
  input  logic             ksa_done,
  input  logic             dec_done,
  output logic [1:0]       mem_owner,
  output logic [KEY_W-1:0] key,
  output logic [4:0]       res_addr,
  input  logic [7:0]       res_q,
  output logic             busy,
  output logic             done,
  output logic             found
);

  localparam logic [4:0]       LAST_BYTE = 5'(MSG_LEN - 1);
  localparam logic [KEY_W-1:0] KEY_ONE   = KEY_W'(1);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] key_hi_q, key_hi_d;
  logic [4:0]       byte_q, byte_d;
  logic             found_q, found_d;
  logic             char_valid;

  rc4_char_check u_char_check (
    .char_in (res_q),
    .valid   (char_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      key_hi_q <= '0;
      byte_q   <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      key_hi_q <= key_hi_d;
      byte_q   <= byte_d;
      found_q  <= found_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    key_hi_d   = key_hi_q;
    byte_d     = byte_q;
    found_d    = found_q;
    init_start = 1'b0;
    ksa_start  = 1'b0;
    dec_start  = 1'b0;
    done       = 1'b0;
    mem_owner  = OWN_NONE;

    unique case (state_q)
      S_IDLE: begin
        // The range is captured at acceptance so later changes on key_lo /
        // key_hi cannot disturb a running search.
        if (start) begin
          key_d    = key_lo;
          key_hi_d = key_hi;
          found_d  = 1'b0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = (key_q > key_hi_q) ? S_FINISH : S_INIT_GO;
      end
      S_INIT_GO: begin
        init_start = 1'b1;
        mem_owner  = OWN_INIT;
        state_d    = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        mem_owner = OWN_INIT;
        if (init_done) state_d = S_KSA_GO;
      end
      S_KSA_GO: begin
        ksa_start = 1'b1;
        mem_owner = OWN_KSA;
        state_d   = S_KSA_WAIT;
      end
      S_KSA_WAIT: begin
        mem_owner = OWN_KSA;
        if (ksa_done) state_d = S_DEC_GO;
      end
      S_DEC_GO: begin
        dec_start = 1'b1;
        mem_owner = OWN_DEC;
        state_d   = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        mem_owner = OWN_DEC;
        if (dec_done) begin
          byte_d  = '0;
          state_d = S_CHK_SETUP;
        end
      end
      S_CHK_SETUP:  state_d = S_CHK_READ;
      S_CHK_READ:   state_d = S_CHK_SAMPLE;
      S_CHK_SAMPLE: begin
        if (!char_valid) begin
          state_d = S_NEXT_KEY;
        end else if (byte_q == LAST_BYTE) begin
          found_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          byte_d  = byte_q + 5'd1;
          state_d = S_CHK_SETUP;
        end
      end
      S_NEXT_KEY: begin
        // Compare before incrementing so key_hi = all-ones cannot wrap.
        if (key_q == key_hi_q) begin
          state_d = S_FINISH;
        end else begin
          key_d   = key_q + KEY_ONE;
          state_d = S_INIT_GO;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign key      = key_q;
  assign res_addr = byte_q;
  assign found    = found_q;

endmodule

// File: doc/rc4_key_search_ctrl.md
RC4_KEY_SEARCH_CTRL -- requirements
Module: rc4_key_search_ctrl

Interface
REQ-001 Parameter MSG_LEN, default 32: number of message bytes checked per candidate key (1..32).
REQ-002 Parameter KEY_W, default 24: candidate key width in bits.
REQ-003 clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_n  input  1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1: one-cycle pulse that begins a search.
REQ-006 key_lo, key_hi  input  KEY_W each: inclusive search range, captured on an accepted start.
REQ-007 init_start, ksa_start, dec_start  output  1 each: one-cycle start pulses to the S-init, key-schedule and decrypt engines.
REQ-008 init_done, ksa_done, dec_done  input  1 each: one-cycle completion pulses from those engines.
REQ-009 mem_owner  output  2: grant for the shared S-memory port (0 none, 1 init, 2 ksa, 3 decrypt).
REQ-010 key  output  KEY_W: candidate key currently applied to the engines.
REQ-011 res_addr  output  5, res_q  input  8: read port to the decrypted-output memory.
REQ-012 busy, done, found  output  1 each: search active; one-cycle end-of-search pulse; key held valid.

Function
REQ-013 States: IDLE, LOAD, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, DEC_GO, DEC_WAIT, CHK_SETUP, CHK_READ, CHK_SAMPLE, NEXT_KEY, FINISH.
REQ-014 IDLE->LOAD on start; start SHALL be ignored in every other state.
REQ-015 LOAD: key<=key_lo, latch key_hi; if key_lo>key_hi go to FINISH with found=0, else go to INIT_GO.
REQ-016 Each *_GO state SHALL pulse its engine start for exactly one cycle, then move to the matching *_WAIT state.
REQ-017 *_WAIT advances only on its own engine's done (INIT->KSA_GO, KSA->DEC_GO, DEC->CHK_SETUP); done pulses from other engines SHALL be ignored.
REQ-018 mem_owner SHALL be 1 in INIT_GO/INIT_WAIT, 2 in KSA_GO/KSA_WAIT, 3 in DEC_GO/DEC_WAIT, and 0 in all other states.
REQ-019 The check loop SHALL run byte index b from 0 to MSG_LEN-1, with res_addr=b held through CHK_SETUP, CHK_READ and CHK_SAMPLE; res_q is sampled in CHK_SAMPLE, giving a 2-cycle read latency.
REQ-020 A byte is valid iff it lies in 0x61..0x7A or equals 0x20.
REQ-021 Invalid byte -> NEXT_KEY immediately; valid byte with b<MSG_LEN-1 -> b+1 and back to CHK_SETUP; valid byte with b=MSG_LEN-1 -> FINISH with found=1.
REQ-022 NEXT_KEY: if key==key_hi -> FINISH with found=0, else key<=key+1 and go to INIT_GO; the compare SHALL precede the increment so that key_hi=all-ones never wraps.
REQ-023 FINISH: done=1 for one cycle, then IDLE.
REQ-024 On return to IDLE, found and key SHALL hold their last values until the next accepted start; busy=0 only in IDLE.
REQ-025 Worst-case cycles per rejected key = engine latencies + 6 + 3*MSG_LEN.

Reset
REQ-026 reset_n=0 at any edge SHALL force IDLE, key=0, res_addr=0, mem_owner=0, and all start, busy, done and found outputs to 0, including mid-search.
REQ-027 An engine done that arrives in the first cycle after reset SHALL be ignored.

Structure
REQ-028 The state enum, the mem_owner encodings and the valid-character bounds SHALL live in the shared package rc4_pkg.
REQ-029 The byte-validity test SHALL be a sub-module rc4_char_check: 8-bit input, 1-bit valid output, combinational.
REQ-030 Engines and memories SHALL be external to this module; it contains no memory.

Verification
REQ-031 key_lo=key_hi=0x000249, engine models pass, res_q all 0x61 -> three start pulses, 32*3 check cycles, done with found=1 and key=0x000249.
REQ-032 key_lo=0, key_hi=3, res_q byte 5 = 0x41 for keys 0..2 and all 0x20 for key 3 -> found=1, key=3, exactly four init_start pulses.
REQ-033 key_lo=5, key_hi=4 -> done 2 cycles after start, found=0, no engine start pulses.
REQ-034 key_lo=key_hi=0xFFFFFF, invalid data -> found=0, key stays 0xFFFFFF, no wrap and no second iteration.
REQ-035 Assert reset_n=0 during KSA_WAIT, then start a new search -> all outputs 0 after reset, and the new search starts cleanly from LOAD.
REQ-036 Spurious dec_done injected during INIT_WAIT, and start pulsed while busy -> both ignored, state and key unchanged.
